config_frame_loader: RTL

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

---
 rtl/cfg_loader_pkg.sv | 24 ++
 rtl/config_frame_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared types and header layout for the configuration frame loader.
package cfg_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] MARKER = 8'hC5;

    // Header word layout: [31:24] marker, [12:8] frame index, [7:0] column index.
    localparam int MARKER_MSB = 31;
    localparam int MARKER_LSB = 24;
    localparam int FIDX_MSB   = 12;
    localparam int FIDX_LSB   = 8;
    localparam int CIDX_MSB   = 7;
    localparam int CIDX_LSB   = 0;

    localparam int FIDX_W = FIDX_MSB - FIDX_LSB + 1;
    localparam int CIDX_W = CIDX_MSB - CIDX_LSB + 1;

endpackage

// File: rtl/config_frame_loader.sv
// Loads one header plus NUM_ROWS data words into FrameData, then fires one frame strobe.
// Optional frame counter port frames_done is enabled by defining CFG_LOADER_STATS_EN.
module config_frame_loader
    import cfg_loader_pkg::*;
#(
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int NUM_ROWS           = 4,
    parameter int NUM_COLS           = 4
) (
    input  logic                                   CLK,
    input  logic                                   resetn,
    // s_data is taken on a rising edge where s_valid and s_ready are both 1;
    // s_ready depends only on the current state, never on s_valid.
    input  logic [31:0]                            s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic [NUM_ROWS*FRAME_BITS_PER_ROW-1:0] FrameData,
    output logic [NUM_COLS*MAX_FRAMES_PER_COL-1:0] FrameStrobe,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   err,
    input  logic                                   err_clr
`ifdef CFG_LOADER_STATS_EN
    ,
    output logic [15:0]                            frames_done
`endif
);

    localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int STROBE_W = NUM_COLS * MAX_FRAMES_PER_COL;

    state_t              state;
    state_t              state_next;
    logic [ROW_W-1:0]    row_q;
    logic [FIDX_W-1:0]   frame_q;
    logic [CIDX_W-1:0]   col_q;
    logic [7:0]          hdr_marker;
    logic [FIDX_W-1:0]   hdr_frame;
    logic [CIDX_W-1:0]   hdr_col;
    logic                accept;
    logic                hdr_ok;
    logic                last_row;
    logic                load_done;
    logic [STROBE_W-1:0] strobe_next;
    int                  strobe_idx;

    assign s_ready    = (state == IDLE) || (state == DATA);
    assign busy       = (state != IDLE);
    assign frame_done = (state == HOLD);
    assign accept     = s_valid && s_ready;

    assign hdr_marker = s_data[MARKER_MSB:MARKER_LSB];
    assign hdr_frame  = s_data[FIDX_MSB:FIDX_LSB];
    assign hdr_col    = s_data[CIDX_MSB:CIDX_LSB];
    assign hdr_ok     = (hdr_marker == MARKER)
                     && (int'(hdr_frame) < MAX_FRAMES_PER_COL)
                     && (int'(hdr_col) < NUM_COLS);

    assign last_row  = (int'(row_q) == NUM_ROWS - 1);
    assign load_done = (state == DATA) && accept && last_row;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && hdr_ok) state_next = DATA;
            DATA:    if (load_done)        state_next = STROBE;
            STROBE:                        state_next = HOLD;
            HOLD:                          state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Strobe is decoded while the last row is accepted so the register holds it during STROBE.
    always_comb begin
        strobe_next = '0;
        strobe_idx  = int'(col_q) * MAX_FRAMES_PER_COL + int'(frame_q);
        if (load_done) begin
            for (int i = 0; i < STROBE_W; i++) begin
                strobe_next[i] = (i == strobe_idx);
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            FrameData   <= '0;
            FrameStrobe <= '0;
            row_q       <= '0;
            frame_q     <= '0;
            col_q       <= '0;
            err         <= 1'b0;
        end else begin
            FrameStrobe <= strobe_next;
            if (err_clr) begin
                err <= 1'b0;
            end
            // A new header error wins over a simultaneous clear.
            if (state == IDLE && accept) begin
                if (hdr_ok) begin
                    frame_q <= hdr_frame;
                    col_q   <= hdr_col;
                    row_q   <= '0;
                end else begin
                    err <= 1'b1;
                end
            end
            if (state == DATA && accept) begin
                FrameData[int'(row_q)*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW]
                    <= FRAME_BITS_PER_ROW'(s_data);
                if (!last_row) begin
                    row_q <= row_q + ROW_W'(1);
                end
            end
        end
    end

`ifdef CFG_LOADER_STATS_EN
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            frames_done <= 16'd0;
        end else if (state == HOLD) begin
            frames_done <= frames_done + 16'd1;
        end
    end
`endif

endmodule
